// File: rtl/sd_cmd_pkt_seq.sv
// ---------------------------------------------------------------------------------------------
// sd_cmd_pkt_seq
//
// Purpose:
//   Holds a writable table of SD CMD-line packets, one packet per fixed-size slot. The init or
//   transfer FSM selects a slot with cmd_sel/cmd_load and kicks it off with start. The packet
//   bytes are then streamed to the CMD line shifter over a valid/ready handshake. Bytes 1..4
//   (the 32-bit argument, MSB first) can be replaced by arg_data on a per-packet basis.
//
// Optional feature (macro SDPKT_CRC7_EN):
//   When defined, CRC7 (x^7+x^3+1, init 0) is accumulated over bytes 0..PKT_BYTES-2 exactly as
//   they are output, and the final byte is replaced by {crc7, 1'b1}. When undefined, the final
//   byte is taken from the table and no CRC logic exists.
//
// Parameters (legal ranges):
//   PKT_BYTES  : bytes per packet, 6 <= PKT_BYTES <= SLOT_BYTES
//   SLOT_BYTES : table stride per slot, power of two
//   NUM_CMDS   : number of slots
//   SEL_W      : cmd_sel width, >= clog2(NUM_CMDS)
//   ADDR_W     : table address width, NUM_CMDS*SLOT_BYTES <= 2**ADDR_W
//
// Ports:
//   i_clk        : clock, rising edge
//   i_reset      : synchronous active-high reset (table contents are kept)
//   i_cmd_sel    : command slot index
//   i_cmd_load   : latch base = cmd_sel*SLOT_BYTES (IDLE only)
//   i_start      : begin streaming the loaded slot (IDLE only)
//   i_arg_en     : sampled with start, override bytes 1..4 with i_arg_data
//   i_arg_data   : argument, byte1 = [31:24]
//   i_tbl_we     : table write strobe (IDLE only, dropped while busy)
//   i_tbl_waddr  : table write address
//   i_tbl_wdata  : table write data
//   o_pkt_data   : current packet byte
//   o_pkt_valid  : o_pkt_data valid
//   i_pkt_ready  : consumer accepts byte on valid & ready
//   o_pkt_last   : high with the final byte of the packet
//   o_busy       : high in every state except IDLE
//   o_done       : one-cycle pulse after the last byte is accepted
//   o_sel_err    : one-cycle pulse on an out-of-range cmd_sel load
// ---------------------------------------------------------------------------------------------
module sd_cmd_pkt_seq #(
    parameter int unsigned PKT_BYTES  = 6,
    parameter int unsigned SLOT_BYTES = 8,
    parameter int unsigned NUM_CMDS   = 32,
    parameter int unsigned SEL_W      = 5,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [SEL_W-1:0]  i_cmd_sel,
    input  logic              i_cmd_load,
    input  logic              i_start,
    input  logic              i_arg_en,
    input  logic [31:0]       i_arg_data,
    input  logic              i_tbl_we,
    input  logic [ADDR_W-1:0] i_tbl_waddr,
    input  logic [7:0]        i_tbl_wdata,
    output logic [7:0]        o_pkt_data,
    output logic              o_pkt_valid,
    input  logic              i_pkt_ready,
    output logic              o_pkt_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sel_err
);

    localparam int unsigned CNT_W = $clog2(SLOT_BYTES);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StStream, StDone} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_pkt_data;
    logic              r_pkt_valid;
    logic              r_pkt_last;
    logic              r_sel_err;
    logic              r_arg_en;
    logic [31:0]       r_arg_data;
    logic [7:0]        r_rd_data;
    logic [7:0]        r_tbl [DEPTH];

    state_t            w_state_next;
    logic [ADDR_W-1:0] w_base_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [7:0]        w_pkt_data_next;
    logic              w_pkt_valid_next;
    logic              w_pkt_last_next;
    logic              w_sel_err_next;
    logic              w_arg_en_next;
    logic [31:0]       w_arg_data_next;
    logic              w_rd_en;
    logic              w_tbl_we;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_sel_base;
    logic              w_sel_ok;
    logic [7:0]        w_arg_byte;
    logic              w_is_arg;
    logic [7:0]        w_load_byte;

    // base+count wraps modulo 2**ADDR_W; count never passes SLOT_BYTES-1
    assign w_rd_addr  = r_base + ADDR_W'(r_count);
    assign w_sel_base = ADDR_W'(i_cmd_sel) << CNT_W;
    assign w_sel_ok   = 32'(i_cmd_sel) < NUM_CMDS;
    assign w_is_arg   = r_arg_en && (r_count >= CNT_W'(1)) && (r_count <= CNT_W'(4));

    always_comb begin
        unique case (r_count)
            CNT_W'(1): w_arg_byte = r_arg_data[31:24];
            CNT_W'(2): w_arg_byte = r_arg_data[23:16];
            CNT_W'(3): w_arg_byte = r_arg_data[15:8];
            default:   w_arg_byte = r_arg_data[7:0];
        endcase
    end

`ifdef SDPKT_CRC7_EN
    logic [6:0] r_crc;

    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    always_comb begin
        w_load_byte = w_is_arg ? w_arg_byte : r_rd_data;
        if (r_count == LAST_CNT) begin
            w_load_byte = {r_crc, 1'b1};
        end
    end

    // Accumulates on each LOAD of bytes 0..PKT_BYTES-2, so it is complete by the final LOAD
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_crc <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_crc <= '0;
        end else if (r_state == StLoad && r_count != LAST_CNT) begin
            r_crc <= crc7_byte(r_crc, w_load_byte);
        end
    end
`else
    always_comb begin
        w_load_byte = w_is_arg ? w_arg_byte : r_rd_data;
    end
`endif

    always_comb begin
        w_state_next     = r_state;
        w_base_next      = r_base;
        w_count_next     = r_count;
        w_pkt_data_next  = r_pkt_data;
        w_pkt_valid_next = r_pkt_valid;
        w_pkt_last_next  = r_pkt_last;
        w_sel_err_next   = 1'b0;
        w_arg_en_next    = r_arg_en;
        w_arg_data_next  = r_arg_data;
        w_rd_en          = 1'b0;
        w_tbl_we         = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_tbl_we = i_tbl_we;
                if (i_cmd_load) begin
                    if (w_sel_ok) begin
                        w_base_next = w_sel_base;
                    end else begin
                        w_base_next    = '0;
                        w_sel_err_next = 1'b1;
                    end
                end
                // A same-cycle load lands in r_base before FETCH reads it
                if (i_start) begin
                    w_arg_en_next   = i_arg_en;
                    w_arg_data_next = i_arg_data;
                    w_count_next    = '0;
                    w_state_next    = StFetch;
                end
            end
            StFetch: begin
                w_rd_en      = 1'b1;
                w_state_next = StLoad;
            end
            StLoad: begin
                w_pkt_data_next  = w_load_byte;
                w_pkt_valid_next = 1'b1;
                w_pkt_last_next  = (r_count == LAST_CNT);
                w_state_next     = StStream;
            end
            StStream: begin
                if (r_pkt_valid && i_pkt_ready) begin
                    w_pkt_valid_next = 1'b0;
                    w_pkt_last_next  = 1'b0;
                    if (r_pkt_last) begin
                        w_state_next = StDone;
                    end else begin
                        w_count_next = r_count + CNT_W'(1);
                        w_state_next = StFetch;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_base      <= '0;
            r_count     <= '0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_last  <= 1'b0;
            r_sel_err   <= 1'b0;
            r_arg_en    <= 1'b0;
            r_arg_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_base      <= w_base_next;
            r_count     <= w_count_next;
            r_pkt_data  <= w_pkt_data_next;
            r_pkt_valid <= w_pkt_valid_next;
            r_pkt_last  <= w_pkt_last_next;
            r_sel_err   <= w_sel_err_next;
            r_arg_en    <= w_arg_en_next;
            r_arg_data  <= w_arg_data_next;
        end
    end

    // Packet table: not reset, write only in IDLE, registered read
    always_ff @(posedge i_clk) begin
        if (w_tbl_we) begin
            r_tbl[i_tbl_waddr] <= i_tbl_wdata;
        end
        if (w_rd_en) begin
            r_rd_data <= r_tbl[w_rd_addr];
        end
    end

    assign o_pkt_data  = r_pkt_data;
    assign o_pkt_valid = r_pkt_valid;
    assign o_pkt_last  = r_pkt_last;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_sel_err   = r_sel_err;

endmodule
